// File: rtl/bypass_pkg.sv
// Shared constants and helpers for the operand bypass path: the select code
// that means "register file", the select-field width, and the mapping from a
// forwarding-source index to its select code.
package bypass_pkg;

    // Select code meaning "operand comes from the register file".
    localparam int SEL_RF = 0;

    // Width of a select field able to name the RF plus num_fwd sources.
    function automatic int sel_width(input int num_fwd);
        return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
    endfunction

    // Forwarding source i is reported as select code i+1 (0 is reserved for RF).
    function automatic int src_to_sel(input int src_idx);
        return src_idx + 1;
    endfunction

endpackage

// File: rtl/operand_fwd_select.sv
// Combinational priority select for one source operand. Source 0 is the
// youngest producer and wins over older ones; x0 is never forwarded. The
// winner's readiness is reported so the caller can raise a load-use hazard
// even when an older, ready source also matches.
module operand_fwd_select
    import bypass_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5,
    parameter int SEL_W   = 2
) (
    input  logic [REG_AW-1:0]         rs_addr_i,
    input  logic [XLEN-1:0]           rf_data_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD-1:0]        fwd_ready_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    output logic [XLEN-1:0]           data_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic                      not_ready_o
);

    logic [NUM_FWD-1:0] match;

    // Per-source address match; a zero source address never matches.
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign match[gi] = fwd_valid_i[gi]
                            && (fwd_rd_i[gi*REG_AW +: REG_AW] == rs_addr_i)
                            && (rs_addr_i != '0);
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index is left standing.
    always_comb begin
        data_o      = rf_data_i;
        sel_o       = SEL_W'(SEL_RF);
        not_ready_o = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (match[i]) begin
                data_o      = fwd_data_i[i*XLEN +: XLEN];
                sel_o       = SEL_W'(src_to_sel(i));
                not_ready_o = !fwd_ready_i[i];
            end
        end
    end

endmodule

// File: rtl/operand_bypass_reg.sv
// ID/EX operand register with parametrised forwarding. Each operand is picked
// from the register file or one of NUM_FWD forwarding sources, then registered.
// A load-use dependency (winning source not ready) holds the operands and
// inserts a bubble; a counter tracks how many captured instructions used
// forwarding.
module operand_bypass_reg
    import bypass_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int NUM_FWD = 2,
    parameter  int REG_AW  = 5,
    parameter  int CNT_W   = 16,
    localparam int SEL_W   = sel_width(NUM_FWD)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      in_valid,
    input  logic [REG_AW-1:0]         rs1_addr,
    input  logic [REG_AW-1:0]         rs2_addr,
    input  logic [XLEN-1:0]           rs1_rf,
    input  logic [XLEN-1:0]           rs2_rf,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic                      hazard_o,
    output logic                      out_valid,
    output logic [XLEN-1:0]           op1_o,
    output logic [XLEN-1:0]           op2_o,
    output logic [SEL_W-1:0]          sel1_o,
    output logic [SEL_W-1:0]          sel2_o,
    output logic [CNT_W-1:0]          fwd_count
);

    logic [XLEN-1:0]  op1_sel, op2_sel;
    logic [SEL_W-1:0] sel1_sel, sel2_sel;
    logic             nr1, nr2;
    logic             any_fwd;
    logic             capture;

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  op1_q, op1_d;
    logic [XLEN-1:0]  op2_q, op2_d;
    logic [SEL_W-1:0] sel1_q, sel1_d;
    logic [SEL_W-1:0] sel2_q, sel2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    operand_fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .SEL_W   (SEL_W)
    ) u_sel_rs1 (
        .rs_addr_i   (rs1_addr),
        .rf_data_i   (rs1_rf),
        .fwd_valid_i (fwd_valid),
        .fwd_ready_i (fwd_ready),
        .fwd_rd_i    (fwd_rd),
        .fwd_data_i  (fwd_data),
        .data_o      (op1_sel),
        .sel_o       (sel1_sel),
        .not_ready_o (nr1)
    );

    operand_fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .SEL_W   (SEL_W)
    ) u_sel_rs2 (
        .rs_addr_i   (rs2_addr),
        .rf_data_i   (rs2_rf),
        .fwd_valid_i (fwd_valid),
        .fwd_ready_i (fwd_ready),
        .fwd_rd_i    (fwd_rd),
        .fwd_data_i  (fwd_data),
        .data_o      (op2_sel),
        .sel_o       (sel2_sel),
        .not_ready_o (nr2)
    );

    // Load-use stall request; deliberately blind to stall_i/flush_i.
    assign hazard_o = in_valid && (nr1 || nr2);
    assign any_fwd  = (sel1_sel != SEL_W'(SEL_RF)) || (sel2_sel != SEL_W'(SEL_RF));
    assign capture  = !flush_i && !stall_i && !hazard_o;

    // Next-state for the ID/EX register: flush > stall > bubble > capture.
    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sel1_d  = sel1_q;
        sel2_d  = sel2_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            op1_d   = '0;
            op2_d   = '0;
            sel1_d  = '0;
            sel2_d  = '0;
        end else if (stall_i) begin
            // everything holds
        end else if (hazard_o) begin
            valid_d = 1'b0;
        end else begin
            valid_d = in_valid;
            op1_d   = op1_sel;
            op2_d   = op2_sel;
            sel1_d  = sel1_sel;
            sel2_d  = sel2_sel;
        end
        // Counter saturates instead of wrapping.
        if (capture && in_valid && any_fwd && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register; reset overrides stall, flush and hazard in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign op1_o     = op1_q;
    assign op2_o     = op2_q;
    assign sel1_o    = sel1_q;
    assign sel2_o    = sel2_q;
    assign fwd_count = cnt_q;

endmodule

// File: tb/tb_operand_bypass_reg.sv
// Directed bench for operand_bypass_reg: priority select, x0, load-use bubble,
// stall hold, flush, and counter saturation (small counter width).
module tb_operand_bypass_reg;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 2;
    localparam int SEL_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      stall_i;
    logic                      flush_i;
    logic                      in_valid;
    logic [REG_AW-1:0]         rs1_addr;
    logic [REG_AW-1:0]         rs2_addr;
    logic [XLEN-1:0]           rs1_rf;
    logic [XLEN-1:0]           rs2_rf;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_ready;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      hazard_o;
    logic                      out_valid;
    logic [XLEN-1:0]           op1_o;
    logic [XLEN-1:0]           op2_o;
    logic [SEL_W-1:0]          sel1_o;
    logic [SEL_W-1:0]          sel2_o;
    logic [CNT_W-1:0]          fwd_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    operand_bypass_reg #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_rf    (rs1_rf),
        .rs2_rf    (rs2_rf),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .hazard_o  (hazard_o),
        .out_valid (out_valid),
        .op1_o     (op1_o),
        .op2_o     (op2_o),
        .sel1_o    (sel1_o),
        .sel2_o    (sel2_o),
        .fwd_count (fwd_count)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle; one log line per transaction.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        $display("[TB] cyc %0d: valid=%0b op1=%h sel1=%0d op2=%h sel2=%0d cnt=%0d",
                 cycle, out_valid, op1_o, sel1_o, op2_o, sel2_o, fwd_count);
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rs1_rf    = '0;
        rs2_rf    = '0;
        fwd_valid = '0;
        fwd_ready = '1;
        fwd_rd    = '0;
        fwd_data  = '0;
    endtask

    task automatic set_fwd(input logic [REG_AW-1:0] rd0, input logic [XLEN-1:0] d0,
                           input logic [REG_AW-1:0] rd1, input logic [XLEN-1:0] d1);
        fwd_rd   = {rd1, rd0};
        fwd_data = {d1, d0};
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_tests++; if (op1_o !== 32'h0) begin n_fail++; $display("FAIL reset_op1 got %h want 0", op1_o); end
        n_tests++; if (op2_o !== 32'h0) begin n_fail++; $display("FAIL reset_op2 got %h want 0", op2_o); end
        n_tests++; if ({sel1_o, sel2_o} !== 4'h0) begin n_fail++; $display("FAIL reset_sel got %h want 0", {sel1_o, sel2_o}); end
        n_tests++; if (fwd_count !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", fwd_count); end
    endtask

    task automatic test_priority();
        idle_inputs();
        in_valid  = 1'b1;
        rs1_addr  = 5'd5;  rs1_rf = 32'h1111;
        rs2_addr  = 5'd3;  rs2_rf = 32'h3333;
        fwd_valid = 2'b11;
        set_fwd(5'd5, 32'hAAAA, 5'd5, 32'hBBBB);
        #1;
        n_tests++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL prio_hazard got %0b want 0", hazard_o); end
        step();
        n_tests++; if (op1_o !== 32'hAAAA) begin n_fail++; $display("FAIL prio_op1 got %h want 0000aaaa", op1_o); end
        n_tests++; if (sel1_o !== 2'd1) begin n_fail++; $display("FAIL prio_sel1 got %0d want 1", sel1_o); end
        n_tests++; if (op2_o !== 32'h3333) begin n_fail++; $display("FAIL prio_op2_rf got %h want 00003333", op2_o); end
        n_tests++; if (sel2_o !== 2'd0) begin n_fail++; $display("FAIL prio_sel2 got %0d want 0", sel2_o); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_valid got %0b want 1", out_valid); end
        n_tests++; if (fwd_count !== 2'd1) begin n_fail++; $display("FAIL prio_cnt got %0d want 1", fwd_count); end
        // Youngest source not writing: older source 1 takes over.
        fwd_valid = 2'b10;
        step();
        n_tests++; if (op1_o !== 32'hBBBB) begin n_fail++; $display("FAIL older_op1 got %h want 0000bbbb", op1_o); end
        n_tests++; if (sel1_o !== 2'd2) begin n_fail++; $display("FAIL older_sel1 got %0d want 2", sel1_o); end
        n_tests++; if (fwd_count !== 2'd2) begin n_fail++; $display("FAIL older_cnt got %0d want 2", fwd_count); end
    endtask

    task automatic test_x0();
        idle_inputs();
        in_valid  = 1'b1;
        fwd_valid = 2'b01;
        set_fwd(5'd0, 32'hFFFF, 5'd0, 32'h0);
        step();
        n_tests++; if (op1_o !== 32'h0) begin n_fail++; $display("FAIL x0_op1 got %h want 0", op1_o); end
        n_tests++; if (sel1_o !== 2'd0) begin n_fail++; $display("FAIL x0_sel1 got %0d want 0", sel1_o); end
        n_tests++; if (fwd_count !== 2'd2) begin n_fail++; $display("FAIL x0_cnt got %0d want 2", fwd_count); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        in_valid  = 1'b1;
        rs1_addr  = 5'd1;  rs1_rf = 32'h0101;
        rs2_addr  = 5'd7;  rs2_rf = 32'h7777;
        fwd_valid = 2'b11;
        fwd_ready = 2'b10;  // youngest not ready, older ready: must still stall
        set_fwd(5'd7, 32'hDEAD, 5'd7, 32'h9999);
        #1;
        n_tests++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL lu_hazard got %0b want 1", hazard_o); end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %0b want 0", out_valid); end
        n_tests++; if (op2_o !== 32'h0) begin n_fail++; $display("FAIL lu_op2_hold got %h want 0", op2_o); end
        fwd_ready = 2'b11;
        set_fwd(5'd7, 32'h1234, 5'd7, 32'h9999);
        #1;
        n_tests++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_clr got %0b want 0", hazard_o); end
        step();
        n_tests++; if (op2_o !== 32'h1234) begin n_fail++; $display("FAIL lu_op2 got %h want 00001234", op2_o); end
        n_tests++; if (sel2_o !== 2'd1) begin n_fail++; $display("FAIL lu_sel2 got %0d want 1", sel2_o); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_valid got %0b want 1", out_valid); end
        n_tests++; if (op1_o !== 32'h0101) begin n_fail++; $display("FAIL lu_op1 got %h want 00000101", op1_o); end
        n_tests++; if (fwd_count !== 2'd3) begin n_fail++; $display("FAIL lu_cnt got %0d want 3", fwd_count); end
    endtask

    task automatic test_stall();
        idle_inputs();
        in_valid = 1'b1;
        rs1_addr = 5'd3;  rs1_rf = 32'h10;
        step();
        n_tests++; if (op1_o !== 32'h10) begin n_fail++; $display("FAIL stall_pre_op1 got %h want 00000010", op1_o); end
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rs1_rf    = 32'h20 + k;
            fwd_valid = 2'b01;
            set_fwd(5'd3, 32'h5000 + k, 5'd0, 32'h0);
            in_valid  = k[0];
            step();
            n_tests++; if (op1_o !== 32'h10) begin n_fail++; $display("FAIL stall_op1[%0d] got %h want 00000010", k, op1_o); end
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %0b want 1", k, out_valid); end
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid  = 1'b1;
        stall_i   = 1'b1;
        flush_i   = 1'b1;
        rs1_addr  = 5'd4;
        fwd_valid = 2'b01;
        fwd_ready = 2'b00;
        set_fwd(5'd4, 32'hCAFE, 5'd0, 32'h0);
        #1;
        n_tests++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL flush_hazard got %0b want 1", hazard_o); end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        n_tests++; if ({op1_o, op2_o} !== 64'h0) begin n_fail++; $display("FAIL flush_ops got %h want 0", {op1_o, op2_o}); end
        n_tests++; if (fwd_count !== 2'd3) begin n_fail++; $display("FAIL flush_cnt got %0d want 3", fwd_count); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (fwd_count !== 2'd0) begin n_fail++; $display("FAIL sat_start got %0d want 0", fwd_count); end
        in_valid  = 1'b1;
        rs1_addr  = 5'd5;
        fwd_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            set_fwd(5'd5, 32'h100 + k, 5'd0, 32'h0);
            step();
            n_tests++; if (fwd_count !== exp_cnt[k]) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, fwd_count, exp_cnt[k]); end
        end
        // Reset while a hazard and a stall are both active.
        fwd_ready = 2'b00;
        stall_i   = 1'b1;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (fwd_count !== 2'd0) begin n_fail++; $display("FAIL sat_rst_cnt got %0d want 0", fwd_count); end
        n_tests++; if (op1_o !== 32'h0) begin n_fail++; $display("FAIL sat_rst_op1 got %h want 0", op1_o); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_priority();
        test_x0();
        test_load_use();
        test_stall();
        test_flush();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
